fifo_wr_adapter: RTL and testbench
==================================

# fifo_wr_adapter

Write-side companion to the FWFT read adapter used by the NoU FIFOs. It converts an upstream valid/ready stream into the FIFO's `wr_en`/`full` write port. A two-entry skid buffer lets `s_ready_o` be driven straight from a flop, so no combinational path runs from `fifo_full_i` back to the producer. It sits between a NoU producer and the FIFO's `wr_en_i`/`wr_data_i`/`full_o` pins and sustains one beat per cycle.

## Interface
- `WIDTH`, default 512: data width in bits.
- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush_i` input 1: synchronous clear of buffered beats.
- `s_valid_i` input 1: producer has a beat.
- `s_ready_o` output 1: adapter can take a beat; driven directly from a flop.
- `s_data_i` input WIDTH: producer data.
- `fifo_full_i` input 1: FIFO full flag.
- `fifo_wr_en_o` output 1: FIFO write strobe.
- `fifo_din_o` output WIDTH: FIFO write data; driven directly from the output register.
- `occupancy_o` output 2: number of buffered beats (0, 1 or 2).

## Operation
- Definitions:
  - accept = `s_valid_i & s_ready_o`.
  - write = `fifo_wr_en_o`, which is `out_vld & ~fifo_full_i`. This is the only combinational input-to-output path.
- Storage:
  - `out_reg`/`out_vld` drives `fifo_din_o`.
  - `skid_reg`/`skid_vld` catches a beat accepted while `out_reg` is stalled.
- State machine, encoded by {`skid_vld`, `out_vld`}:
  - EMPTY: accept → ONE, with `out_reg` ← `s_data_i`.
  - ONE, accept & write → ONE, with `out_reg` ← `s_data_i`.
  - ONE, accept & ~write → TWO, with `skid_reg` ← `s_data_i`.
  - ONE, ~accept & write → EMPTY.
  - ONE, ~accept & ~write → ONE.
  - TWO, write → ONE, with `out_reg` ← `skid_reg`.
  - TWO, ~write → TWO.
  - Accept cannot occur in TWO because `s_ready_o` is 0 there.
- `s_ready_o` register: loaded each cycle with (next state ≠ TWO).
- `occupancy_o` = `out_vld` + `skid_vld`.
- Ordering: beats reach the FIFO strictly in acceptance order. No beat is dropped or duplicated, except on flush.
- `flush_i`:
  - Next state is EMPTY and `s_ready_o` is 1 on the following cycle.
  - A beat accepted in the flush cycle is discarded.
  - A write occurring in the flush cycle still completes, since the FIFO samples it.
- `rst` has priority over `flush_i`.
- Data registers load only on the transitions listed; otherwise they hold.

## Timing
- Reset values: `s_ready_o`=0, `fifo_wr_en_o`=0, `fifo_din_o`=0, `occupancy_o`=0, state EMPTY.
- `s_ready_o` rises on the first clock edge after `rst` deasserts.
- Latency: a beat accepted at edge N appears on `fifo_din_o` with `fifo_wr_en_o`=1 in cycle N+1 when `fifo_full_i`=0.
- Throughput: 1 beat/cycle sustained while `fifo_full_i`=0. Occupancy stays at 1 in this steady state.
- Full asserted:
  - At most 2 beats are absorbed.
  - `s_ready_o` falls the cycle after the second beat is accepted.
  - `fifo_wr_en_o` stays 0 while `fifo_full_i`=1.
- Full deasserting in TWO:
  - The write happens the same cycle.
  - `s_ready_o` = 1 on the next cycle.
  - The skid beat is written one cycle after the out beat.
- `rst` mid-transfer: buffered beats are lost; the outputs follow the reset values on the next edge.

## Test plan
- Reset, then streaming: `rst` high for 3 cycles, then `s_valid_i`=1 with data 0x1,0x2,0x3,… and `fifo_full_i`=0. Required: `s_ready_o`=1 from cycle 1; `fifo_wr_en_o`=1 each cycle from cycle 2; `fifo_din_o` = 0x1,0x2,… in order; `occupancy_o`=1.
- Backpressure: `fifo_full_i`=1 while streaming 0xA,0xB,0xC. Required: 0xA and 0xB are absorbed; `occupancy_o`=2; `s_ready_o`=0; 0xC is held by the producer; `fifo_wr_en_o`=0.
- Release: drop `fifo_full_i` after the backpressure scenario. Required: writes 0xA, 0xB, 0xC on consecutive cycles and `s_ready_o` returns to 1 one cycle after the first write.
- Flush in TWO: with 0xA/0xB buffered and `fifo_full_i`=1, pulse `flush_i`. Required: next cycle `occupancy_o`=0, `s_ready_o`=1, no write of 0xA/0xB.
- Random stress: random `s_valid_i`/`fifo_full_i` over 10k cycles against a scoreboard. Required: exact in-order match, no `fifo_wr_en_o` while `fifo_full_i`=1, `occupancy_o` never 3.
- Mid-operation reset: assert `rst` in TWO. Required: all outputs at reset values next cycle and no further writes of the old data.

Source files
------------

// File: rtl/fifo_wr_adapter.sv
// fifo_wr_adapter: valid/ready stream to FIFO wr_en/full write port.
// A two-entry skid buffer (out_reg + skid_reg) lets s_ready_o come straight
// from a flop, so fifo_full_i never reaches the producer combinationally.
// The only input-to-output combinational path is fifo_full_i -> fifo_wr_en_o.
module fifo_wr_adapter #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             fifo_full_i,
    output logic             fifo_wr_en_o,
    output logic [WIDTH-1:0] fifo_din_o,
    output logic [1:0]       occupancy_o
);

    // State is literally {skid_vld, out_vld}; the skid entry is only ever
    // valid when the output entry is valid, so 2'b10 never occurs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] out_reg_q,  out_reg_d;
    logic [WIDTH-1:0] skid_reg_q, skid_reg_d;
    logic             s_ready_q,  s_ready_d;

    logic out_vld;
    logic skid_vld;
    logic accept;
    logic write;

    assign out_vld  = state_q[0];
    assign skid_vld = state_q[1];
    assign accept   = s_valid_i & s_ready_q;
    assign write    = out_vld & ~fifo_full_i;

    assign s_ready_o    = s_ready_q;
    assign fifo_wr_en_o = write;
    assign fifo_din_o   = out_reg_q;
    assign occupancy_o  = {1'b0, out_vld} + {1'b0, skid_vld};

    // Next-state and data-register loads for the skid buffer.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case/if tree can leave it unassigned and infer a latch.
        state_d    = state_q;
        out_reg_d  = out_reg_q;
        skid_reg_d = skid_reg_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    out_reg_d = s_data_i;
                end
            end
            ONE: begin
                if (accept && write) begin
                    out_reg_d = s_data_i;
                end else if (accept) begin
                    state_d    = TWO;
                    skid_reg_d = s_data_i;
                end else if (write) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // s_ready_q is 0 here, so no accept can arrive in this state.
                if (write) begin
                    state_d   = ONE;
                    out_reg_d = skid_reg_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush drops all buffered beats, including one accepted this cycle.
        // A write in this cycle has already been sampled by the FIFO.
        // Data registers hold, since flush is not a load transition.
        if (flush_i) begin
            state_d    = EMPTY;
            out_reg_d  = out_reg_q;
            skid_reg_d = skid_reg_q;
        end

        s_ready_d = (state_d != TWO);
    end

    // State, ready and data registers; reset has priority over flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
            out_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            out_reg_q <= out_reg_d;
        end
    end

    // Skid data register: qualified by skid_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: wide data storage is left unreset when a valid bit guards it;
        // only out_reg is reset because fifo_din_o has a defined reset value.
        skid_reg_q <= skid_reg_d;
    end

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed and randomized self-checking bench for fifo_wr_adapter.
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge, then the bench advances to the next rising edge.
module tb_fifo_wr_adapter;

    localparam int WIDTH = 512;

    logic             clk;
    logic             rst;
    logic             flush_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [WIDTH-1:0] s_data_i;
    logic             fifo_full_i;
    logic             fifo_wr_en_o;
    logic [WIDTH-1:0] fifo_din_o;
    logic [1:0]       occupancy_o;

    int errors = 0;
    int checks = 0;

    fifo_wr_adapter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_din_o   (fifo_din_o),
        .occupancy_o  (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; fifo_full_i = 1'b0;
        next_cycle();
        repeat (2) begin
            @(negedge clk);
            checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b exp 0", s_ready_o); end
            checks++; if (fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b exp 0", fifo_wr_en_o); end
            checks++; if (fifo_din_o !== '0) begin errors++; $display("FAIL reset_din: got %0h exp 0", fifo_din_o); end
            checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occupancy_o); end
            next_cycle();
        end
    endtask

    task automatic test_stream();
        rst = 1'b0; s_valid_i = 1'b1; s_data_i = WIDTH'(1);
        // First cycle out of reset: ready still low, rises at the coming edge.
        @(negedge clk);
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL stream_ready0: got %0b exp 0", s_ready_o); end
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            s_data_i = WIDTH'(k + 1);
            @(negedge clk);
            checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d: got %0b exp 1", k, s_ready_o); end
            if (k == 0) begin
                checks++; if (fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL stream_wr_en0: got %0b exp 0", fifo_wr_en_o); end
                checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL stream_occ0: got %0d exp 0", occupancy_o); end
            end else begin
                checks++; if (fifo_wr_en_o !== 1'b1) begin errors++; $display("FAIL stream_wr_en k=%0d: got %0b exp 1", k, fifo_wr_en_o); end
                checks++; if (fifo_din_o !== WIDTH'(k)) begin errors++; $display("FAIL stream_din k=%0d: got %0h exp %0h", k, fifo_din_o, k); end
                checks++; if (occupancy_o !== 2'd1) begin errors++; $display("FAIL stream_occ k=%0d: got %0d exp 1", k, occupancy_o); end
            end
            next_cycle();
        end
        s_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b1 || fifo_din_o !== WIDTH'(6)) begin errors++; $display("FAIL stream_last: wr_en=%0b din=%0h exp 1/6", fifo_wr_en_o, fifo_din_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (occupancy_o !== 2'd0 || fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL stream_drain: occ=%0d wr_en=%0b exp 0/0", occupancy_o, fifo_wr_en_o); end
        next_cycle();
    endtask

    // From EMPTY with full asserted: A and B absorbed, C held by the producer.
    task automatic load_two(input string tag);
        fifo_full_i = 1'b1; s_valid_i = 1'b1; s_data_i = WIDTH'('hA);
        @(negedge clk);
        checks++; if (s_ready_o !== 1'b1 || occupancy_o !== 2'd0) begin errors++; $display("FAIL %s_bp1: ready=%0b occ=%0d exp 1/0", tag, s_ready_o, occupancy_o); end
        next_cycle();
        s_data_i = WIDTH'('hB);
        @(negedge clk);
        checks++; if (s_ready_o !== 1'b1 || occupancy_o !== 2'd1 || fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL %s_bp2: ready=%0b occ=%0d wr_en=%0b exp 1/1/0", tag, s_ready_o, occupancy_o, fifo_wr_en_o); end
        next_cycle();
        s_data_i = WIDTH'('hC);
    endtask

    task automatic test_backpressure();
        load_two("bp");
        repeat (2) begin
            @(negedge clk);
            checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b exp 0", s_ready_o); end
            checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d exp 2", occupancy_o); end
            checks++; if (fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL bp_wr_en: got %0b exp 0", fifo_wr_en_o); end
            checks++; if (fifo_din_o !== WIDTH'('hA)) begin errors++; $display("FAIL bp_din: got %0h exp a", fifo_din_o); end
            next_cycle();
        end
    endtask

    task automatic test_release();
        fifo_full_i = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b1 || fifo_din_o !== WIDTH'('hA)) begin errors++; $display("FAIL rel_wr_a: wr_en=%0b din=%0h exp 1/a", fifo_wr_en_o, fifo_din_o); end
        checks++; if (s_ready_o !== 1'b0 || occupancy_o !== 2'd2) begin errors++; $display("FAIL rel_state0: ready=%0b occ=%0d exp 0/2", s_ready_o, occupancy_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b1 || fifo_din_o !== WIDTH'('hB)) begin errors++; $display("FAIL rel_wr_b: wr_en=%0b din=%0h exp 1/b", fifo_wr_en_o, fifo_din_o); end
        checks++; if (s_ready_o !== 1'b1 || occupancy_o !== 2'd1) begin errors++; $display("FAIL rel_state1: ready=%0b occ=%0d exp 1/1", s_ready_o, occupancy_o); end
        next_cycle();
        s_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b1 || fifo_din_o !== WIDTH'('hC)) begin errors++; $display("FAIL rel_wr_c: wr_en=%0b din=%0h exp 1/c", fifo_wr_en_o, fifo_din_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL rel_idle: wr_en=%0b occ=%0d exp 0/0", fifo_wr_en_o, occupancy_o); end
        next_cycle();
    endtask

    task automatic test_flush();
        // Flush in TWO: both buffered beats dropped, nothing written.
        load_two("fl");
        s_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        checks++; if (occupancy_o !== 2'd2 || fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL flush_pre: occ=%0d wr_en=%0b exp 2/0", occupancy_o, fifo_wr_en_o); end
        next_cycle();
        flush_i = 1'b0; fifo_full_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d exp 0", occupancy_o); end
            checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b exp 1", s_ready_o); end
            checks++; if (fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL flush_no_wr: got %0b exp 0", fifo_wr_en_o); end
            next_cycle();
        end
        // Flush in ONE: the in-flight write completes, the accepted beat is dropped.
        s_valid_i = 1'b1; s_data_i = WIDTH'('h11);
        next_cycle();
        s_data_i = WIDTH'('h22); flush_i = 1'b1;
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b1 || fifo_din_o !== WIDTH'('h11)) begin errors++; $display("FAIL flush_one_wr: wr_en=%0b din=%0h exp 1/11", fifo_wr_en_o, fifo_din_o); end
        next_cycle();
        flush_i = 1'b0; s_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en_o !== 1'b0 || occupancy_o !== 2'd0 || s_ready_o !== 1'b1) begin errors++; $display("FAIL flush_one_after: wr_en=%0b occ=%0d ready=%0b exp 0/0/1", fifo_wr_en_o, occupancy_o, s_ready_o); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] sb[$];
        logic [WIDTH-1:0] exp_d;
        int unsigned      next_data = 32'h100;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            s_valid_i   = ($urandom_range(0, 3) != 0);
            fifo_full_i = ($urandom_range(0, 2) == 0);
            s_data_i    = WIDTH'(next_data);
            @(negedge clk);
            checks++; if (occupancy_o !== 2'(sb.size())) begin errors++; $display("FAIL rnd_occ cyc=%0d: got %0d exp %0d", cyc, occupancy_o, sb.size()); end
            if (fifo_wr_en_o === 1'b1) begin
                checks++; if (fifo_full_i) begin errors++; $display("FAIL rnd_wr_full cyc=%0d: got wr_en 1 exp 0", cyc); end
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious cyc=%0d: got write %0h exp none", cyc, fifo_din_o);
                end else begin
                    exp_d = sb.pop_front();
                    if (fifo_din_o !== exp_d) begin errors++; $display("FAIL rnd_data cyc=%0d: got %0h exp %0h", cyc, fifo_din_o, exp_d); end
                end
            end
            if (s_valid_i && s_ready_o === 1'b1) begin
                sb.push_back(s_data_i);
                next_data++;
            end
            next_cycle();
        end
        s_valid_i = 1'b0; fifo_full_i = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (fifo_wr_en_o === 1'b1 && sb.size() != 0) begin
                exp_d = sb.pop_front();
                checks++; if (fifo_din_o !== exp_d) begin errors++; $display("FAIL rnd_drain: got %0h exp %0h", fifo_din_o, exp_d); end
            end
            next_cycle();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d beats unwritten exp 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        load_two("rst");
        rst = 1'b1; s_valid_i = 1'b0;
        next_cycle();
        fifo_full_i = 1'b0;
        @(negedge clk);
        checks++; if (s_ready_o !== 1'b0 || fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL rstmid_ctl: ready=%0b wr_en=%0b exp 0/0", s_ready_o, fifo_wr_en_o); end
        checks++; if (fifo_din_o !== '0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL rstmid_dat: din=%0h occ=%0d exp 0/0", fifo_din_o, occupancy_o); end
        next_cycle();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (fifo_wr_en_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL rstmid_no_wr: wr_en=%0b occ=%0d exp 0/0", fifo_wr_en_o, occupancy_o); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b exp 1", s_ready_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_release();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
